// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary serial adder: trit encoding,
// trit decode helper and the word-sequencing state enum.
package ternary_pkg;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_INV = 2'b11;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CARRY = 1'b1
  } state_t;

  // Decode an encoded trit to its numeric value; the invalid code reads as 0.
  function automatic logic [1:0] trit_val(input logic [1:0] t);
    logic [1:0] v;
    case (t)
      TRIT_0:  v = 2'd0;
      TRIT_1:  v = 2'd1;
      TRIT_2:  v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ternary_full_adder.sv
// Single-trit ternary full adder: sum = (a + b + cin) mod 3, cout = carry.
module ternary_full_adder
  import ternary_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic [2:0] total;

  // Raw sum is 0..5; fold values of 3 and above back into one trit plus carry.
  always_comb begin
    total = {1'b0, trit_val(a)} + {1'b0, trit_val(b)} + {2'b00, cin};
    if (total >= 3'd3) begin
      sum  = 2'(total - 3'd3);
      cout = 1'b1;
    end else begin
      sum  = total[1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/ternary_serial_adder.sv
// Digit-serial adder for unsigned ternary words, LS trit first.
// Each word of N input trits yields N+1 output trits; the last one is the
// final carry and is flagged with out_last.
// Optional macro TERN_INVALID_CHECK_EN: when defined, a 2'b11 operand trit on
// an accepted beat sets the sticky err flag (the trit still adds as 0).
//
// Handshake: a beat moves on an interface when valid && ready are both high
// at a rising edge. The producer keeps in_* stable while in_valid && !in_ready;
// this block keeps out_* stable while out_valid && !out_ready. The single
// output register may be drained and refilled in the same cycle.
module ternary_serial_adder
  import ternary_pkg::*;
#(
  parameter int MAX_TRITS = 8,
  parameter int IDX_W     = $clog2(MAX_TRITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sum,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
  output logic             err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_TRITS - 1);

  state_t           state, state_d;
  logic             carry, carry_d;
  logic [IDX_W-1:0] count, count_d;
  logic             out_free;
  logic             accept;
  logic             load_carry;
  logic [1:0]       fa_sum;
  logic             fa_cout;

  ternary_full_adder u_fa (
    .a    (in_a),
    .b    (in_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state == S_RUN) && out_free;
  assign accept     = in_valid && in_ready;
  assign load_carry = (state == S_CARRY) && out_free;

  // State, carry and trit count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      carry <= 1'b0;
      count <= '0;
    end else begin
      state <= state_d;
      carry <= carry_d;
      count <= count_d;
    end
  end

  // Next-state: a word ends on in_last or when the trit budget is used up.
  always_comb begin
    state_d = state;
    carry_d = carry;
    count_d = count;
    if (accept) begin
      carry_d = fa_cout;
      count_d = count + IDX_W'(1);
      if (in_last || count == LAST_IDX) begin
        state_d = S_CARRY;
      end
    end else if (load_carry) begin
      carry_d = 1'b0;
      count_d = '0;
      state_d = S_RUN;
    end
  end

  // Output register: load a sum trit or the carry trit, else drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= TRIT_0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= fa_sum;
      out_last  <= 1'b0;
      out_idx   <= count;
    end else if (load_carry) begin
      out_valid <= 1'b1;
      out_sum   <= {1'b0, carry};
      out_last  <= 1'b1;
      out_idx   <= count;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TERN_INVALID_CHECK_EN
  // Sticky flag for any invalid operand trit seen on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && (in_a == TRIT_INV || in_b == TRIT_INV)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/ternary_serial_adder.md
Name: ternary_serial_adder

Overview:
- Digit-serial adder for unsigned ternary words. It consumes one trit pair per accepted beat, least-significant trit first.
- It adds the pair plus a registered carry and emits one sum trit per beat. After the last input trit it emits one extra trit holding the final carry.
- It sits directly downstream of the trit-pair source and upstream of the result consumer. It extends the single-trit min/sum/carry datapath into multi-trit words.

Parameters:
- MAX_TRITS, 8: maximum input trits per word. A word is force-terminated at this count.
- IDX_W, $clog2(MAX_TRITS+1): width of the trit index output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_a/in_b/in_last are valid.
- in_ready  output  1  block can accept an input beat this cycle.
- in_a  input  2  operand A trit: 2'b00=0, 2'b01=1, 2'b10=2, 2'b11 invalid.
- in_b  input  2  operand B trit, same encoding.
- in_last  input  1  this beat is the most-significant input trit.
- out_valid  output  1  out_sum/out_last/out_idx are valid.
- out_ready  input  1  consumer accepts the output beat.
- out_sum  output  2  result trit, same encoding; never 2'b11.
- out_last  output  1  this output beat is the final carry trit.
- out_idx  output  IDX_W  position of out_sum within the result word; 0 = LS trit.
- err  output  1  sticky invalid-trit flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - state=S_RUN, carry=0, trit count=0.
  - out_valid=0, out_sum=2'b00, out_last=0, out_idx=0, err=0.
  - Reset asserted mid-word abandons the word. No partial flush.
- Handshakes:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
  - The producer holds inputs stable while in_valid && !in_ready.
  - The block holds out_* stable while out_valid && !out_ready.
- Output register:
  - Single stage.
  - in_ready = (state==S_RUN) && (!out_valid || out_ready). Full throughput; the register can be refilled in the same cycle it drains.
- Latency: a transferred input beat appears on out_* the next cycle.
- Arithmetic per beat:
  - s = a + b + carry, range 0..5.
  - out_sum = s mod 3; next carry = (s >= 3). Carry is only ever 0 or 1.
  - out_idx = count, then count increments.
- States:
  - S_RUN:
    - Accepts beats.
    - Moves to S_CARRY when an accepted beat has in_last=1, or when count==MAX_TRITS-1 at acceptance (forced termination; in_last is ignored in that case).
  - S_CARRY:
    - in_ready=0.
    - When the output register is free or draining, loads out_sum=carry, out_idx=count, out_last=1.
    - Then clears carry and count and returns to S_RUN.
- Every result word therefore has exactly N+1 output trits. out_last is set only on the carry trit.
- A single-trit word (in_last on the first beat) produces 2 output beats.
- in_valid with in_ready=0 has no effect.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: TERN_INVALID_CHECK_EN.
- Defined:
  - An accepted beat with in_a==2'b11 or in_b==2'b11 sets err=1.
  - err stays set until rst.
  - The offending trit is added as value 0.
- Undefined:
  - 2'b11 is decoded as value 0 with no detection.
  - err is tied to 0.

Decomposition:
- Package ternary_pkg:
  - trit encoding constants TRIT_0/TRIT_1/TRIT_2/TRIT_INV.
  - a trit-to-integer decode function.
  - the state enum S_RUN/S_CARRY.
- Sub-module ternary_full_adder, purely combinational:
  - inputs a[1:0], b[1:0], cin (1 bit).
  - outputs sum[1:0], cout (1 bit).
  - instantiated once in the datapath.

Test Plan:
- 12+7: inputs (a,b) = (0,1),(1,2),(1,0,last) back-to-back, out_ready=1 -> out_sum 1,0,2,0 with idx 0..3; out_last only on idx3; 19 = 201 in base 3.
- 8+8: (2,2),(2,2,last) -> out_sum 1,2,1 with out_last on the third beat (16 = 121 in base 3); the carry trit is 1.
- Backpressure: send the 12+7 word, hold out_ready=0 for 3 cycles after the first output -> out_* stays stable and in_ready=0; no beat is lost or duplicated; result is the same as the 12+7 case.
- Forced termination at MAX_TRITS=8: 8 beats of (2,2) with in_last never set -> 9 outputs: 1,2,2,2,2,2,2,2, then carry 1 with out_last; the next beat starts a new word at idx 0.
- Reset mid-word: assert rst after 2 beats of a word -> next cycle out_valid=0, err=0; a fresh word (1,1,last) gives 2,0.
- With TERN_INVALID_CHECK_EN: beat (3,1,last) -> err=1 persists, out_sum 1 then 0; without the macro, err stays 0.
